// File: rtl/neuron_pkg.sv
// neuron_pkg: fp32 width/constants and the FSM state type shared by neuron_mac_seq.
package neuron_pkg;
    localparam int unsigned FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} mac_state_t;
endpackage

// File: rtl/float_adder.sv
// float_adder: combinational fp32 add, round-to-nearest-even with guard/round/sticky bits.
module float_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] Out,
    output logic [31:0] Out_test,
    output logic [7:0]  shift,
    output logic        c_out
);
    logic [31:0] big;
    logic [31:0] sml;
    logic [27:0] mb;
    logic [27:0] ms;
    logic [27:0] sum;
    logic [26:0] n;
    logic [7:0]  d;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic        rnd;
    logic [30:0] mag;

    always_comb begin
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {2'b01, big[22:0], 3'b000};
        ms = {2'b01, sml[22:0], 3'b000};
        // align the smaller operand; shifted-out bits collapse into the sticky LSB
        if (d >= 8'd28)
            ms = 28'd1;
        else
            ms = (ms >> d) | {27'd0, |(ms & ~(28'hFFF_FFFF << d))};
        e     = 10'(big[30:23]);
        sum   = (big[31] == sml[31]) ? mb + ms : mb - ms;
        c_out = sum[27];
        lz    = '0;
        if (sum[27]) begin
            n = sum[27:1] | {26'd0, sum[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 5'(26 - i);
            n = sum[26:0] << lz;
            e = e - 10'(lz);
        end
        rnd      = n[2] & ((|n[1:0]) | n[3]);
        mag      = {e[7:0], n[25:3]} + 31'(rnd);
        Out_test = {big[31], e[7:0], n[25:3]};
        shift    = d;
        if (sml[30:23] == 8'd0)
            Out = big;
        else if (sum == 28'd0)
            Out = 32'd0;
        else if ($signed(e) <= 10'sd0)
            Out = {big[31], 31'd0};
        else if ($signed(e) >= 10'sd255 || mag[30:23] == 8'hFF)
            Out = {big[31], 8'hFF, 23'd0};
        else
            Out = {big[31], mag};
    end
endmodule

// File: rtl/float_mult.sv
// float_mult: combinational fp32 multiply, round-to-nearest-even, subnormals flushed to zero.
module float_mult (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] z
);
    logic        sgn;
    logic [47:0] mp;
    logic [9:0]  e;
    logic [22:0] man;
    logic        g;
    logic        st;
    logic        rnd;
    logic [30:0] mag;

    always_comb begin
        sgn = x[31] ^ y[31];
        mp  = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e   = 10'(x[30:23]) + 10'(y[30:23]) - 10'd127;
        if (mp[47]) begin
            man = mp[46:24];
            g   = mp[23];
            st  = |mp[22:0];
            e   = e + 10'd1;
        end else begin
            man = mp[45:23];
            g   = mp[22];
            st  = |mp[21:0];
        end
        rnd = g & (st | man[0]);
        mag = {e[7:0], man} + 31'(rnd);
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || $signed(e) <= 10'sd0)
            z = {sgn, 31'd0};
        else if ($signed(e) >= 10'sd255 || mag[30:23] == 8'hFF)
            z = {sgn, 8'hFF, 23'd0};
        else
            z = {sgn, mag};
    end
endmodule

// File: rtl/neuron_mac_dp.sv
// neuron_mac_dp: shared multiplier, product register and fp32 accumulator for neuron_mac_seq.
module neuron_mac_dp
    import neuron_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [FP_W-1:0] act,
    input  logic [FP_W-1:0] wgt,
    output logic [FP_W-1:0] sum_c
);
    logic [FP_W-1:0] prod_c;
    logic [FP_W-1:0] prod_q;
    logic            prod_vld;
    logic [FP_W-1:0] acc_q;
    logic [31:0]     add_test_unused;
    logic [7:0]      add_shift_unused;
    logic            add_cout_unused;

    float_mult u_mult (.x(act), .y(wgt), .z(prod_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= FP_ZERO;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= load;
            if (load) prod_q <= prod_c;
        end
    end

    float_adder u_add (
        .a        (acc_q),
        .b        (prod_q),
        .Out      (sum_c),
        .Out_test (add_test_unused),
        .shift    (add_shift_unused),
        .c_out    (add_cout_unused)
    );

    // fixed left-to-right summation: one product folded in per valid cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           acc_q <= FP_ZERO;
        else if (clr)      acc_q <= FP_ZERO;
        else if (prod_vld) acc_q <= sum_c;
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: serial fp32 multiply-accumulate for one neuron.
// Define NEURON_MAC_RELU_EN to rectify the output (hidden layers); otherwise the raw sum passes.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int unsigned N_INPUTS = 15,
    parameter int unsigned AW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_data,
    output logic [AW-1:0]   w_addr,
    input  logic [FP_W-1:0] w_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_data
);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);

    mac_state_t      state_q;
    mac_state_t      state_d;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_d;
    logic            accept_c;
    logic            clr_c;
    logic [FP_W-1:0] sum_c;
    logic [FP_W-1:0] res_c;

    assign w_addr = idx_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_c    = 1'b0;
        accept_c = in_valid && in_ready;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                idx_d   = '0;
                clr_c   = 1'b1;
            end
            ACCUM: if (accept_c) begin
                if (idx_q == LAST_IDX) state_d = DRAIN;
                else                   idx_d   = idx_q + AW'(1);
            end
            DRAIN:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in DRAIN the adder output already holds the final sum
`ifdef NEURON_MAC_RELU_EN
    assign res_c = sum_c[FP_W-1] ? FP_ZERO : sum_c;
`else
    assign res_c = sum_c;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= FP_ZERO;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy      <= (state_d != IDLE);
            in_ready  <= (state_d == ACCUM);
            out_valid <= (state_d == DONE);
            if (state_q == DRAIN) out_data <= res_c;
        end
    end

    neuron_mac_dp u_dp (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_c),
        .load  (accept_c),
        .act   (in_data),
        .wgt   (w_data),
        .sum_c (sum_c)
    );
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: real-arithmetic fp32 reference model plus directed handshake scenarios.
module tb_neuron_mac_seq;
    import neuron_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, out_ready;
    logic [31:0] in_data, w_data, out_data;
    logic        busy, in_ready, out_valid;
    logic [1:0]  w_addr;

    logic        start15, in_valid15, out_ready15;
    logic [31:0] in_data15, w_data15, out_data15;
    logic        busy15, in_ready15, out_valid15;
    logic [3:0]  w_addr15;

    logic [31:0] wrom  [4];
    logic [31:0] cur_x [4];
    logic [31:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign w_data   = wrom[w_addr];
    assign w_data15 = FP_ONE;

    neuron_mac_seq #(.N_INPUTS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    neuron_mac_seq #(.N_INPUTS(15)) u_dut15 (
        .clk(clk), .rst(rst), .start(start15), .busy(busy15),
        .in_valid(in_valid15), .in_ready(in_ready15), .in_data(in_data15),
        .w_addr(w_addr15), .w_data(w_data15),
        .out_valid(out_valid15), .out_ready(out_ready15), .out_data(out_data15)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // fp32 <-> real; products of two fp32 values are exact in double precision
    function automatic real fp2r(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 0.0;
        return $bitstoreal({x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] b;
        int          fe;
        logic [30:0] v;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        fe = int'(b[62:52]) - 896;
        if (fe <= 0) return {b[63], 31'd0};
        v = {8'(fe), b[51:29]};
        if (b[28] && ((|b[27:0]) || b[29])) v = v + 31'd1;
        if (fe >= 255 || v[30:23] == 8'hFF) return {b[63], 8'hFF, 23'd0};
        return {b[63], v};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] p, input logic [31:0] q);
        return r2fp(fp2r(p) * fp2r(q));
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
        return r2fp(fp2r(p) + fp2r(q));
    endfunction

    function automatic logic [31:0] model_neuron();
        logic [31:0] acc;
        acc = FP_ZERO;
        for (int i = 0; i < 4; i++) acc = fp_add(acc, fp_mul(cur_x[i], wrom[i]));
`ifdef NEURON_MAC_RELU_EN
        if (acc[31]) acc = FP_ZERO;
`endif
        return acc;
    endfunction

    // scoreboard compare on every cycle the N=4 result is presented
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check32("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check32("out_data", out_data, exp_q[0]);
                check32("in_ready_in_done", 32'(in_ready), 32'd0);
                check32("busy_in_done", 32'(busy), 32'd1);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run4(input bit stall, input int bp, input bit start_in_done, input int abort_after);
        int          i, cyc;
        logic        ok;
        logic [31:0] e;
        e = model_neuron();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        i = 0;
        cyc = 0;
        while (i < 4 && cyc < 200) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = cur_x[i];
            start    = stall && (cyc == 2);
            @(negedge clk);
            check32("in_ready_accum", 32'(in_ready), 32'd1);
            check32("w_addr_idx", 32'(w_addr), 32'(i));
            ok = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (ok) i++;
            if (abort_after != 0 && i == abort_after) begin
                rst = 1'b1;
                in_valid = 1'b0;
                start = 1'b0;
                #1;
                check32("rst_busy", 32'(busy), 32'd0);
                check32("rst_in_ready", 32'(in_ready), 32'd0);
                check32("rst_out_valid", 32'(out_valid), 32'd0);
                check32("rst_w_addr", 32'(w_addr), 32'd0);
                check32("rst_out_data", out_data, FP_ZERO);
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (cyc >= 200) check32("accept_timeout", 32'(i), 32'd4);
        exp_q.push_back(e);
        @(negedge clk);
        check32("drain_out_valid", 32'(out_valid), 32'd0);
        check32("drain_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 out_ready = (bp == 0);
        @(negedge clk);
        check32("latency_out_valid", 32'(out_valid), 32'd1);
        for (int k = 1; k < bp; k++) begin
            @(posedge clk); #1 start = start_in_done && (k == 2);
        end
        if (bp > 0) begin
            @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check32("post_hs_out_valid", 32'(out_valid), 32'd0);
        check32("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          i, cyc;
        logic        ok;
        logic [31:0] neg_req;
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        start15 = 1'b0; in_valid15 = 1'b0; out_ready15 = 1'b0; in_data15 = FP_ONE;
        for (int k = 0; k < 4; k++) begin wrom[k] = FP_ONE; cur_x[k] = FP_ONE; end
        repeat (2) @(posedge clk);
        #1;
        check32("reset_busy", 32'(busy), 32'd0);
        check32("reset_in_ready", 32'(in_ready), 32'd0);
        check32("reset_out_valid", 32'(out_valid), 32'd0);
        check32("reset_w_addr", 32'(w_addr), 32'd0);
        check32("reset_out_data", out_data, FP_ZERO);
        check32("reset_busy15", 32'(busy15), 32'd0);
        check32("reset_out_data15", out_data15, FP_ZERO);
        rst = 1'b0;

        check32("model_mul", fp_mul(32'h3F80_0000, 32'h4040_0000), 32'h4040_0000);
        check32("model_mul_neg", fp_mul(32'hBE94_6670, 32'h4000_0000), 32'hBF14_6670);
        check32("model_add", fp_add(32'h4040_0000, 32'h3F80_0000), 32'h4080_0000);
        check32("model_cancel", fp_add(32'h3F80_0000, 32'hBF80_0000), 32'h0000_0000);
        check32("model_round", r2fp(0.1), 32'h3DCC_CCCD);

        // N=15, unit weights and inputs, no stalls
        @(posedge clk); #1 start15 = 1'b1;
        @(posedge clk); #1 start15 = 1'b0; in_valid15 = 1'b1;
        i = 0;
        cyc = 0;
        while (i < 15 && cyc < 100) begin
            @(negedge clk);
            check32("n15_in_ready", 32'(in_ready15), 32'd1);
            check32("n15_w_addr", 32'(w_addr15), 32'(i));
            ok = in_ready15;
            @(posedge clk); #1;
            cyc++;
            if (ok) i++;
        end
        in_valid15 = 1'b0;
        check32("n15_accept_cycles", 32'(cyc), 32'd15);
        @(negedge clk);
        check32("n15_drain_out_valid", 32'(out_valid15), 32'd0);
        @(posedge clk); #1 out_ready15 = 1'b1;
        @(negedge clk);
        check32("n15_latency_out_valid", 32'(out_valid15), 32'd1);
        check32("n15_out_data", out_data15, 32'h4170_0000);
        @(posedge clk); #1 out_ready15 = 1'b0;
        @(negedge clk);
        check32("n15_post_hs_busy", 32'(busy15), 32'd0);
        check32("n15_post_hs_out_valid", 32'(out_valid15), 32'd0);

        // unit weights, inputs 1..4
        cur_x[0] = 32'h3F80_0000; cur_x[1] = 32'h4000_0000;
        cur_x[2] = 32'h4040_0000; cur_x[3] = 32'h4080_0000;
        check32("model_sum10", model_neuron(), 32'h4120_0000);
        run4(1'b0, 0, 1'b0, 0);

        // negative weights
        for (int k = 0; k < 4; k++) wrom[k] = 32'hBF80_0000;
`ifdef NEURON_MAC_RELU_EN
        neg_req = 32'h0000_0000;
`else
        neg_req = 32'hC120_0000;
`endif
        check32("model_neg", model_neuron(), neg_req);
        run4(1'b0, 0, 1'b0, 0);

        // random in_valid gaps, fractional negative weight, random activations
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                wrom[k]  = 32'hBE94_6670;
                cur_x[k] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 133)), 23'($urandom)};
            end
            run4(1'b1, 0, 1'b0, 0);
        end

        // output backpressure with a start pulse while DONE
        for (int k = 0; k < 4; k++) begin
            wrom[k]  = FP_ONE;
            cur_x[k] = 32'h3FC0_0000 + 32'(k) * 32'h0010_0000;
        end
        run4(1'b0, 5, 1'b1, 0);

        // reset after the 2nd accept, then a clean 4.0 neuron
        run4(1'b0, 0, 1'b0, 2);
        for (int k = 0; k < 4; k++) begin wrom[k] = FP_ONE; cur_x[k] = FP_ONE; end
        check32("model_sum4", model_neuron(), 32'h4080_0000);
        run4(1'b0, 0, 1'b0, 0);

        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
